// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle sequencing controller.
//   - RV64 major opcodes recognised by the controller
//   - FSM state enumeration
//   - ALUOp encodings driven to the ALU control decoder
//   - trap_cause codes reported alongside the trap pulse
//   - is_known_op(): true for the opcodes the datapath can execute
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } ctrl_state_e;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic logic is_known_op(input logic [6:0] op);
        logic known;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH: known = 1'b1;
            default:                                          known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: counts memory wait cycles and flags a bus timeout.
// Parameters:
//   TIMEOUT  wait limit in cycles; 0 disables expiry entirely
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   clr      restart the count (priority over en)
//   en       a request is outstanding and not ready this cycle
//   expired  count has reached TIMEOUT
module ctrl_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // A zero limit would give a zero-width counter; keep at least one bit.
    localparam int            CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT  = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam bit            TMO_ON = (TIMEOUT != 0);

    logic [CW-1:0] cnt_r;

    assign expired = TMO_ON && (cnt_r == LIMIT);

    // Wait counter: clear on state entry, saturate at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en && TMO_ON && !expired) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for the multicycle RV64 datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, issuing the
// datapath strobes per state, with a req/ready memory handshake, a bus
// timeout and a trap state for illegal opcodes.
// Parameters:
//   TIMEOUT   max memory wait cycles (0 disables the timeout)
//   CNT_W     width of the performance counters
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode              IR[6:0], stable from DECODE until the next FETCH
//   mem_ready           memory completes the current request this cycle
//   mem_req             memory request, held until mem_ready
//   PCWrite, IRWrite    update PC / latch IR
//   RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch  datapath strobes
//   ALUOp               00 add, 01 branch compare, 10 R-type, 11 I-type
//   trap, trap_cause    one-cycle trap pulse and its cause (01 illegal, 10 timeout)
//   instret, cycles     performance counters
// Configuration macro:
//   CTRL_PERF_EN        when defined, instret/cycles count; otherwise tied to 0
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             Branch,
    output logic [1:0]       ALUOp,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);

    ctrl_state_e state_r;
    ctrl_state_e state_next_s;
    logic [1:0]  cause_r;
    logic [1:0]  cause_next_s;
    logic        retire_s;
    logic        timer_clr_s;
    logic        timer_en_s;
    logic        timer_expired_s;

    // Every state change restarts the wait count, so FETCH and MEM always
    // begin their dwell at zero; only a self-loop keeps counting.
    assign timer_clr_s = (state_next_s != state_r);
    assign timer_en_s  = mem_req && !mem_ready;

    ctrl_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (timer_expired_s)
    );

    // State and latched trap cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cause_r <= CAUSE_NONE;
        end else begin
            state_r <= state_next_s;
            cause_r <= cause_next_s;
        end
    end

    // Next-state logic and per-state datapath strobes.
    always_comb begin
        state_next_s = state_r;
        cause_next_s = cause_r;
        retire_s     = 1'b0;
        mem_req      = 1'b0;
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ALUSrc       = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemtoReg     = 1'b0;
        Branch       = 1'b0;
        ALUOp        = ALUOP_ADD;
        trap         = 1'b0;
        trap_cause   = CAUSE_NONE;

        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                // A completing access wins over a simultaneous expiry.
                if (mem_ready) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    state_next_s = ST_DECODE;
                end else if (timer_expired_s) begin
                    state_next_s = ST_TRAP;
                    cause_next_s = CAUSE_TIMEOUT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end

            ST_DECODE: begin
                if (is_known_op(opcode)) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_TRAP;
                    cause_next_s = CAUSE_ILLEGAL;
                end
            end

            ST_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: begin
                        ALUOp        = ALUOP_ADD;
                        ALUSrc       = 1'b1;
                        state_next_s = ST_MEM;
                    end
                    OP_RTYPE: begin
                        ALUOp        = ALUOP_RTYPE;
                        state_next_s = ST_WB;
                    end
                    OP_ITYPE: begin
                        ALUOp        = ALUOP_ITYPE;
                        ALUSrc       = 1'b1;
                        state_next_s = ST_WB;
                    end
                    OP_BRANCH: begin
                        // PC update is gated by the ALU zero flag outside.
                        ALUOp        = ALUOP_BRANCH;
                        Branch       = 1'b1;
                        retire_s     = 1'b1;
                        state_next_s = ST_FETCH;
                    end
                    default: begin
                        // Opcode changed after DECODE; treat as illegal.
                        state_next_s = ST_TRAP;
                        cause_next_s = CAUSE_ILLEGAL;
                    end
                endcase
            end

            ST_MEM: begin
                mem_req  = 1'b1;
                MemRead  = (opcode == OP_LOAD);
                MemWrite = (opcode != OP_LOAD);
                if (mem_ready) begin
                    if (opcode == OP_LOAD) begin
                        state_next_s = ST_WB;
                    end else begin
                        retire_s     = 1'b1;
                        state_next_s = ST_FETCH;
                    end
                end else if (timer_expired_s) begin
                    state_next_s = ST_TRAP;
                    cause_next_s = CAUSE_TIMEOUT;
                end else begin
                    state_next_s = ST_MEM;
                end
            end

            ST_WB: begin
                RegWrite     = 1'b1;
                MemtoReg     = (opcode == OP_LOAD);
                retire_s     = 1'b1;
                state_next_s = ST_FETCH;
            end

            ST_TRAP: begin
                // Datapath steers PC to the trap vector while trap is high.
                trap         = 1'b1;
                trap_cause   = cause_r;
                PCWrite      = 1'b1;
                cause_next_s = CAUSE_NONE;
                state_next_s = ST_FETCH;
            end

            default: begin
                state_next_s = ST_IDLE;
                cause_next_s = CAUSE_NONE;
            end
        endcase
    end

`ifdef CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] instret_r;
    logic [CNT_W-1:0] cycles_r;

    // Free-running cycle count and retired-instruction count, both wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_r  <= {CNT_W{1'b0}};
            instret_r <= {CNT_W{1'b0}};
        end else begin
            cycles_r <= cycles_r + CNT_ONE;
            if (retire_s) begin
                instret_r <= instret_r + CNT_ONE;
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    assign instret = instret_r;
    assign cycles  = cycles_r;
`else
    logic perf_unused_s;

    assign perf_unused_s = retire_s;
    assign instret       = {CNT_W{1'b0}};
    assign cycles        = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: self-checking bench for multicycle_control.
// Each scenario expands instructions into an expected per-cycle trace of
// strobes (from the instruction's class, its wait counts and the timeout
// limit) and compares the DUT against it cycle by cycle, along with the
// retire and cycle counters.
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int TMO   = 15;
    localparam int CNT_W = 64;
`ifdef CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             mem_req, PCWrite, IRWrite, RegWrite, ALUSrc;
    logic             MemRead, MemWrite, MemtoReg, Branch, trap;
    logic [1:0]       ALUOp, trap_cause;
    logic [CNT_W-1:0] instret, cycles;

    multicycle_control #(
        .TIMEOUT (TMO),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ALUSrc     (ALUSrc),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .Branch     (Branch),
        .ALUOp      (ALUOp),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rq, rd, wr, ir, pc, rw, as, mt, br;
        logic [1:0] aop;
        logic       tr;
        logic [1:0] tc;
    } outs_t;

    typedef struct {
        outs_t      exp;
        logic       rdy;
        logic [6:0] op;
        bit         ret;
    } step_t;

    step_t            tq[$];
    outs_t            obs;
    logic [CNT_W-1:0] m_instret = '0;
    logic [CNT_W-1:0] m_cycles  = '0;
    int               n_checks  = 0;
    int               n_fail    = 0;
    int               cyc       = 0;

    assign obs = {mem_req, MemRead, MemWrite, IRWrite, PCWrite, RegWrite,
                  ALUSrc, MemtoReg, Branch, ALUOp, trap, trap_cause};

    function automatic logic [CNT_W-1:0] cnt(input logic [CNT_W-1:0] m);
        return PERF ? m : '0;
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return (op == LD) || (op == ST) || (op == RT) || (op == IT) || (op == BR);
    endfunction

    function automatic outs_t o_fetch(input logic rdy);
        outs_t o = '0;
        o.rq = 1'b1; o.rd = 1'b1; o.ir = rdy; o.pc = rdy;
        return o;
    endfunction

    function automatic outs_t o_exec(input logic [6:0] op);
        outs_t o = '0;
        case (op)
            LD, ST:  begin o.aop = 2'b00; o.as = 1'b1; end
            RT:      o.aop = 2'b10;
            IT:      begin o.aop = 2'b11; o.as = 1'b1; end
            BR:      begin o.aop = 2'b01; o.br = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic outs_t o_mem(input logic [6:0] op);
        outs_t o = '0;
        o.rq = 1'b1; o.rd = (op == LD); o.wr = (op == ST);
        return o;
    endfunction

    function automatic outs_t o_wb(input logic [6:0] op);
        outs_t o = '0;
        o.rw = 1'b1; o.mt = (op == LD);
        return o;
    endfunction

    function automatic outs_t o_trap(input logic [1:0] cause);
        outs_t o = '0;
        o.tr = 1'b1; o.pc = 1'b1; o.tc = cause;
        return o;
    endfunction

    task automatic push(input outs_t e, input logic r, input logic [6:0] op, input bit ret);
        step_t s;
        s.exp = e; s.rdy = r; s.op = op; s.ret = ret;
        tq.push_back(s);
    endtask

    // Expand one instruction (fetch waits wf, memory waits wm) into cycles.
    // A wait count above TMO means the access never completes.
    task automatic build_instr(input logic [6:0] op, input int wf, input int wm);
        int nf = (wf > TMO) ? TMO + 1 : wf;
        int nm = (wm > TMO) ? TMO + 1 : wm;
        for (int i = 0; i < nf; i++) push(o_fetch(1'b0), 1'b0, 7'($urandom), 1'b0);
        if (wf > TMO) begin
            push(o_trap(2'b10), 1'($urandom), 7'($urandom), 1'b0);
            return;
        end
        push(o_fetch(1'b1), 1'b1, 7'($urandom), 1'b0);
        push('0, 1'($urandom), op, 1'b0);
        if (!is_legal(op)) begin
            push(o_trap(2'b01), 1'($urandom), op, 1'b0);
            return;
        end
        push(o_exec(op), 1'($urandom), op, op == BR);
        if (op == BR) return;
        if (op == RT || op == IT) begin
            push(o_wb(op), 1'($urandom), op, 1'b1);
            return;
        end
        for (int i = 0; i < nm; i++) push(o_mem(op), 1'b0, op, 1'b0);
        if (wm > TMO) begin
            push(o_trap(2'b10), 1'($urandom), op, 1'b0);
            return;
        end
        push(o_mem(op), 1'b1, op, op == ST);
        if (op == LD) push(o_wb(op), 1'($urandom), op, 1'b1);
    endtask

    task automatic drive(input step_t s);
        @(negedge clk);
        mem_ready = s.rdy;
        opcode    = s.op;
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        step_t s;
        rst = 1'b1; mem_ready = 1'b0; opcode = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (obs !== outs_t'(0)) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", obs); end
        n_checks++;
        if (instret !== '0) begin n_fail++; $display("FAIL reset_instret got=%0d want=0", instret); end
        n_checks++;
        if (cycles !== '0) begin n_fail++; $display("FAIL reset_cycles got=%0d want=0", cycles); end
        // First cycle after release: still idle, counters still zero.
        rst = 1'b0; #1;
        n_checks++;
        if (obs !== outs_t'(0)) begin n_fail++; $display("FAIL idle_outputs got=%h want=0", obs); end
        n_checks++;
        if (cycles !== '0) begin n_fail++; $display("FAIL idle_cycles got=%0d want=0", cycles); end
        m_instret = '0;
        m_cycles  = 1;
        s.exp = '0;
    endtask

    task automatic test_add();
        step_t s;
        build_instr(RT, 0, 0);
        while (tq.size() != 0) begin
            s = tq.pop_front(); drive(s);
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL add_outputs cyc=%0d got=%h want=%h", cyc, obs, s.exp); end
            n_checks++;
            if (instret !== cnt(m_instret)) begin n_fail++; $display("FAIL add_instret cyc=%0d got=%0d want=%0d", cyc, instret, cnt(m_instret)); end
            n_checks++;
            if (cycles !== cnt(m_cycles)) begin n_fail++; $display("FAIL add_cycles cyc=%0d got=%0d want=%0d", cyc, cycles, cnt(m_cycles)); end
            if (s.ret) m_instret++;
            m_cycles++;
        end
    endtask

    task automatic test_load_wait();
        step_t s;
        build_instr(LD, 0, 2);
        build_instr(IT, 1, 0);
        build_instr(BR, 0, 0);
        while (tq.size() != 0) begin
            s = tq.pop_front(); drive(s);
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL load_outputs cyc=%0d got=%h want=%h", cyc, obs, s.exp); end
            n_checks++;
            if (instret !== cnt(m_instret)) begin n_fail++; $display("FAIL load_instret cyc=%0d got=%0d want=%0d", cyc, instret, cnt(m_instret)); end
            if (s.ret) m_instret++;
            m_cycles++;
        end
    endtask

    task automatic test_illegal();
        step_t s;
        build_instr(7'b1111111, 0, 0);
        build_instr(ST, 0, 1);
        while (tq.size() != 0) begin
            s = tq.pop_front(); drive(s);
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL illegal_outputs cyc=%0d got=%h want=%h", cyc, obs, s.exp); end
            n_checks++;
            if (instret !== cnt(m_instret)) begin n_fail++; $display("FAIL illegal_instret cyc=%0d got=%0d want=%0d", cyc, instret, cnt(m_instret)); end
            if (s.ret) m_instret++;
            m_cycles++;
        end
    endtask

    task automatic test_timeout();
        step_t s;
        build_instr(RT, TMO + 1, 0);   // fetch never ready: trap cause 10
        build_instr(RT, TMO, 0);       // ready on the last allowed cycle
        build_instr(ST, 0, TMO + 1);   // store never ready: trap cause 10
        build_instr(LD, 0, TMO);
        while (tq.size() != 0) begin
            s = tq.pop_front(); drive(s);
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL timeout_outputs cyc=%0d got=%h want=%h", cyc, obs, s.exp); end
            n_checks++;
            if (cycles !== cnt(m_cycles)) begin n_fail++; $display("FAIL timeout_cycles cyc=%0d got=%0d want=%0d", cyc, cycles, cnt(m_cycles)); end
            if (s.ret) m_instret++;
            m_cycles++;
        end
    endtask

    task automatic test_reset_mid_mem();
        step_t s;
        build_instr(ST, 0, 6);
        for (int i = 0; i < 5; i++) begin   // FETCH, DECODE, EXEC, MEM, MEM
            s = tq.pop_front(); drive(s);
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL rstmem_pre cyc=%0d got=%h want=%h", cyc, obs, s.exp); end
            if (s.ret) m_instret++;
            m_cycles++;
        end
        tq.delete();
        @(negedge clk); rst = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (obs !== outs_t'(0)) begin n_fail++; $display("FAIL rstmem_outputs i=%0d got=%h want=0", i, obs); end
            n_checks++;
            if (instret !== '0 || cycles !== '0) begin
                n_fail++; $display("FAIL rstmem_counters i=%0d instret=%0d cycles=%0d want=0", i, instret, cycles);
            end
        end
        rst = 1'b0; #1;
        n_checks++;
        if (obs !== outs_t'(0)) begin n_fail++; $display("FAIL rstmem_idle got=%h want=0", obs); end
        m_instret = '0;
        m_cycles  = 1;
        build_instr(ST, 0, 0);
        while (tq.size() != 0) begin
            s = tq.pop_front(); drive(s);
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL rstmem_post cyc=%0d got=%h want=%h", cyc, obs, s.exp); end
            n_checks++;
            if (cycles !== cnt(m_cycles)) begin n_fail++; $display("FAIL rstmem_cycles cyc=%0d got=%0d want=%0d", cyc, cycles, cnt(m_cycles)); end
            if (s.ret) m_instret++;
            m_cycles++;
        end
    endtask

    task automatic test_back_to_back();
        step_t      s;
        logic [6:0] op;
        logic [6:0] legal[5];
        int         wf, wm;
        legal = '{LD, ST, RT, IT, BR};
        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do op = 7'($urandom); while (is_legal(op));
            end else begin
                op = legal[$urandom_range(0, 4)];
            end
            wf = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(0, 2);
            wm = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(0, 3);
            build_instr(op, wf, wm);
        end
        while (tq.size() != 0) begin
            s = tq.pop_front(); drive(s);
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL b2b_outputs cyc=%0d got=%h want=%h", cyc, obs, s.exp); end
            n_checks++;
            if (instret !== cnt(m_instret)) begin n_fail++; $display("FAIL b2b_instret cyc=%0d got=%0d want=%0d", cyc, instret, cnt(m_instret)); end
            n_checks++;
            if (cycles !== cnt(m_cycles)) begin n_fail++; $display("FAIL b2b_cycles cyc=%0d got=%0d want=%0d", cyc, cycles, cnt(m_cycles)); end
            if (s.ret) m_instret++;
            m_cycles++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
